mpp_hf_detector: RTL



---
 rtl/mpp_hf_pkg.sv | 59 +++++
 rtl/mpp_sym_slicer.sv | 58 +++++
 rtl/mpp_hf_detector.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mpp_hf_pkg.sv
// Shared definitions for the MPP HF signature detector: ternary symbol
// encoding, detector state encoding and the 17-symbol HF signature.
// The signature is held as a packed vector in which symbol i occupies
// bits [2*i+1:2*i]. The sliding window in the detector uses the same layout.
package mpp_hf_pkg;

    typedef enum logic [1:0] {
        SYM_ZERO = 2'b00,
        SYM_POS  = 2'b01,
        SYM_NEG  = 2'b11
    } sym_e;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam int HF_PAT_LEN = 17;
    localparam int WIN_W      = 2 * HF_PAT_LEN;

    // Signature symbol at a given phase: + + - - - + + 0 - - 0 + + 0 - - +
    function automatic logic [1:0] hf_pat_sym(input logic [4:0] idx);
        logic [1:0] s;
        case (idx)
            5'd0:    s = SYM_POS;
            5'd1:    s = SYM_POS;
            5'd2:    s = SYM_NEG;
            5'd3:    s = SYM_NEG;
            5'd4:    s = SYM_NEG;
            5'd5:    s = SYM_POS;
            5'd6:    s = SYM_POS;
            5'd7:    s = SYM_ZERO;
            5'd8:    s = SYM_NEG;
            5'd9:    s = SYM_NEG;
            5'd10:   s = SYM_ZERO;
            5'd11:   s = SYM_POS;
            5'd12:   s = SYM_POS;
            5'd13:   s = SYM_ZERO;
            5'd14:   s = SYM_NEG;
            5'd15:   s = SYM_NEG;
            5'd16:   s = SYM_POS;
            default: s = SYM_ZERO;
        endcase
        return s;
    endfunction

    // Packs the signature into window layout (index 0 in the low bits).
    function automatic logic [WIN_W-1:0] hf_pat_build();
        logic [WIN_W-1:0] v;
        v = {WIN_W{1'b0}};
        for (int i = 0; i < HF_PAT_LEN; i++) begin
            v[2*i +: 2] = hf_pat_sym(5'(i));
        end
        return v;
    endfunction

    localparam logic [WIN_W-1:0] HF_PAT = hf_pat_build();

endpackage

// File: rtl/mpp_sym_slicer.sv
// Registered ternary slicer: maps a signed 24-bit MPP sample to POS / NEG /
// ZERO against a symmetric magnitude threshold. Exactly +/-SLICE_TH slices
// to ZERO. The symbol is held while no sample is valid.
module mpp_sym_slicer
    import mpp_hf_pkg::*;
#(
    parameter int unsigned SLICE_TH = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [23:0] sample_in,
    output logic [1:0]  sym,
    output logic        sym_valid
);

    logic signed [24:0] sample_ext_s;
    logic signed [24:0] th_pos_s;
    logic signed [24:0] th_neg_s;
    logic [1:0]         sym_s;
    logic [1:0]         sym_r;
    logic               sym_valid_r;

    assign sample_ext_s = signed'({sample_in[23], sample_in});
    assign th_pos_s     = signed'(25'(SLICE_TH));
    assign th_neg_s     = -th_pos_s;

    // Threshold decision on the sign-extended sample.
    always_comb begin
        sym_s = SYM_ZERO;
        if (sample_ext_s > th_pos_s) begin
            sym_s = SYM_POS;
        end else if (sample_ext_s < th_neg_s) begin
            sym_s = SYM_NEG;
        end else begin
            sym_s = SYM_ZERO;
        end
    end

    // Symbol register and one-cycle-delayed valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_r       <= SYM_ZERO;
            sym_valid_r <= 1'b0;
        end else begin
            sym_valid_r <= sample_valid;
            if (sample_valid) begin
                sym_r <= sym_s;
            end else begin
                sym_r <= sym_r;
            end
        end
    end

    assign sym       = sym_r;
    assign sym_valid = sym_valid_r;

endmodule

// File: rtl/mpp_hf_detector.sv
// MPP ring-hover HF signature detector. Slices the sample stream to ternary
// symbols, searches a 17-symbol window for the HF signature, then tracks its
// phase and reports lock, period boundaries and symbol errors.
// Optional build macro MPP_HF_DET_STATS_EN: enables the saturating
// err_count statistic; without it err_count is tied to zero.
module mpp_hf_detector
    import mpp_hf_pkg::*;
#(
    parameter int unsigned SLICE_TH   = 1000,
    parameter int unsigned MISS_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [23:0] sample_in,
    output logic        locked,
    output logic        period_strobe,
    output logic        symbol_err,
    output logic [15:0] period_count,
    output logic [15:0] err_count
);

    localparam logic [3:0] MISS_LIM_C = 4'(MISS_LIMIT);
    localparam logic [4:0] PHASE_LAST = 5'(HF_PAT_LEN - 1);

    logic [1:0]       sym_s;
    logic             sym_valid_s;

    state_e           state_r;
    state_e           state_nx_s;
    logic [WIN_W-1:0] window_r;
    logic [WIN_W-1:0] window_nx_s;
    logic [WIN_W-1:0] win_shift_s;
    logic [4:0]       phase_r;
    logic [4:0]       phase_nx_s;
    logic [3:0]       miss_r;
    logic [3:0]       miss_nx_s;
    logic [3:0]       miss_inc_s;
    logic             locked_r;
    logic             locked_nx_s;
    logic             strobe_r;
    logic             strobe_nx_s;
    logic             err_r;
    logic             err_nx_s;
    logic [15:0]      pcount_r;
    logic [15:0]      pcount_nx_s;
    logic [15:0]      pcount_inc_s;
    logic             sym_match_s;
    logic             loss_s;

    mpp_sym_slicer #(
        .SLICE_TH (SLICE_TH)
    ) u_slicer (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .sym          (sym_s),
        .sym_valid    (sym_valid_s)
    );

    // Newest symbol enters at index 16 (top bits); oldest drops off index 0.
    assign win_shift_s  = {sym_s, window_r[WIN_W-1:2]};
    assign sym_match_s  = (sym_s == hf_pat_sym(phase_r));
    assign miss_inc_s   = miss_r + 4'd1;
    assign loss_s       = (!sym_match_s) && (miss_inc_s >= MISS_LIM_C);
    assign pcount_inc_s = (pcount_r == 16'hFFFF) ? pcount_r : (pcount_r + 16'd1);

    // Search/track FSM next-state and output decode; pulses default low.
    always_comb begin
        state_nx_s  = state_r;
        window_nx_s = window_r;
        phase_nx_s  = phase_r;
        miss_nx_s   = miss_r;
        locked_nx_s = locked_r;
        pcount_nx_s = pcount_r;
        strobe_nx_s = 1'b0;
        err_nx_s    = 1'b0;
        if (sym_valid_s) begin
            case (state_r)
                ST_SEARCH: begin
                    window_nx_s = win_shift_s;
                    if (win_shift_s == HF_PAT) begin
                        state_nx_s  = ST_LOCKED;
                        locked_nx_s = 1'b1;
                        phase_nx_s  = 5'd0;
                        pcount_nx_s = 16'd0;
                        miss_nx_s   = 4'd0;
                    end else begin
                        state_nx_s  = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    phase_nx_s = (phase_r == PHASE_LAST) ? 5'd0 : (phase_r + 5'd1);
                    err_nx_s   = !sym_match_s;
                    miss_nx_s  = sym_match_s ? 4'd0 : miss_inc_s;
                    if (loss_s) begin
                        // Loss of lock wins over a coincident period boundary.
                        state_nx_s  = ST_SEARCH;
                        locked_nx_s = 1'b0;
                        window_nx_s = {WIN_W{1'b0}};
                        miss_nx_s   = 4'd0;
                    end else if (phase_r == PHASE_LAST) begin
                        strobe_nx_s = 1'b1;
                        pcount_nx_s = pcount_inc_s;
                    end else begin
                        strobe_nx_s = 1'b0;
                    end
                end
                default: begin
                    state_nx_s  = ST_SEARCH;
                    locked_nx_s = 1'b0;
                    window_nx_s = {WIN_W{1'b0}};
                    miss_nx_s   = 4'd0;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // State, window, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_SEARCH;
            window_r <= {WIN_W{1'b0}};
            phase_r  <= 5'd0;
            miss_r   <= 4'd0;
            locked_r <= 1'b0;
            strobe_r <= 1'b0;
            err_r    <= 1'b0;
            pcount_r <= 16'd0;
        end else begin
            state_r  <= state_nx_s;
            window_r <= window_nx_s;
            phase_r  <= phase_nx_s;
            miss_r   <= miss_nx_s;
            locked_r <= locked_nx_s;
            strobe_r <= strobe_nx_s;
            err_r    <= err_nx_s;
            pcount_r <= pcount_nx_s;
        end
    end

    assign locked        = locked_r;
    assign period_strobe = strobe_r;
    assign symbol_err    = err_r;
    assign period_count  = pcount_r;

`ifdef MPP_HF_DET_STATS_EN
    logic [15:0] errcnt_r;

    // Lifetime error statistic; survives lock loss, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errcnt_r <= 16'd0;
        end else if (err_nx_s && (errcnt_r != 16'hFFFF)) begin
            errcnt_r <= errcnt_r + 16'd1;
        end else begin
            errcnt_r <= errcnt_r;
        end
    end

    assign err_count = errcnt_r;
`else
    assign err_count = 16'd0;
`endif

endmodule
